// File: rtl/mem_target_responder.sv
// Word-addressed memory responder: one request at a time over valid/ready, a fixed number of
// wait states, then one held response per request.
module mem_target_responder #(
    parameter int unsigned ADDR_WIDTH     = 28,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned WAIT_STATES    = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int unsigned MemDepth = 2 ** MEM_DEPTH_LOG2;
    localparam logic [3:0]  WaitLoad = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    started_q;
    logic                    lat_we_q;
    logic [ADDR_WIDTH-1:0]   lat_addr_q;
    logic [DATA_WIDTH-1:0]   lat_wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [MemDepth];

    logic                      accept;
    logic                      access;
    logic                      acc_we;
    logic [ADDR_WIDTH-1:0]     acc_addr;
    logic [DATA_WIDTH-1:0]     acc_wdata;
    logic                      acc_in_range;
    logic [MEM_DEPTH_LOG2-1:0] acc_index;
    logic                      mem_wr_en;

    // started_q keeps req_ready low until the first edge after reset release.
    assign req_ready  = started_q && (state_q == StIdle);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == StResp);
    assign busy       = (state_q != StIdle);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        access     = 1'b0;
        acc_we     = lat_we_q;
        acc_addr   = lat_addr_q;
        acc_wdata  = lat_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES != 0) begin
                        state_d    = StWait;
                        wait_cnt_d = WaitLoad;
                    end else begin
                        // No wait states: the access uses the live request at the accept edge.
                        state_d   = StResp;
                        access    = 1'b1;
                        acc_we    = req_we;
                        acc_addr  = req_addr;
                        acc_wdata = req_wdata;
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign acc_in_range = ((acc_addr >> MEM_DEPTH_LOG2) == '0);
    assign acc_index    = acc_addr[MEM_DEPTH_LOG2-1:0];
    assign mem_wr_en    = access && acc_we && acc_in_range;

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (access) begin
            err_d   = !acc_in_range;
            rdata_d = (!acc_we && acc_in_range) ? mem[acc_index] : '0;
        end else if ((state_q == StResp) && resp_ready) begin
            rdata_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 4'd0;
            started_q   <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            started_q  <= 1'b1;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            if (accept) begin
                lat_we_q    <= req_we;
                lat_addr_q  <= req_addr;
                lat_wdata_q <= req_wdata;
            end
        end
    end

    // Storage survives reset; an aborted access never reaches the write enable.
    always_ff @(posedge clock) begin
        if (mem_wr_en) begin
            mem[acc_index] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_mem_target_responder.sv
// Bench for mem_target_responder: one instance with two wait states, one with none, checked
// against a flat word-array model of the storage.
module tb_mem_target_responder;

    localparam int AW = 28;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset_n    [2];
    logic          req_valid  [2];
    logic          req_ready  [2];
    logic          req_we     [2];
    logic [AW-1:0] req_addr   [2];
    logic [DW-1:0] req_wdata  [2];
    logic          resp_valid [2];
    logic          resp_ready [2];
    logic [DW-1:0] resp_rdata [2];
    logic          resp_err   [2];
    logic          busy       [2];

    always #5 clock = ~clock;

    mem_target_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(10), .WAIT_STATES(2)
    ) u_dut_ws2 (
        .clock(clock), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .busy(busy[0])
    );

    mem_target_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(10), .WAIT_STATES(0)
    ) u_dut_ws0 (
        .clock(clock), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .busy(busy[1])
    );

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
    } vec_t;

    vec_t          vecs [$];
    logic [DW-1:0] model_mem   [2][1024];
    bit            model_known [2][1024];
    int            n_pass  = 0;
    int            n_total = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected response from the storage model; commits in-range writes to the model.
    task automatic model_apply(input int d, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata,
                               output logic [DW-1:0] rdata, output bit err);
        err   = (addr >= 28'd1024);
        rdata = '0;
        if (!err) begin
            if (we) begin
                model_mem[d][addr[9:0]]   = wdata;
                model_known[d][addr[9:0]] = 1'b1;
            end else begin
                rdata = model_mem[d][addr[9:0]];
            end
        end
    endtask

    // One full transaction; checks latency, response hold while stalled, and handshake clear.
    task automatic transact(input int d, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int stall, input bit poke,
                            output logic [DW-1:0] rdata, output bit err);
        int n;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("req_ready_before_accept", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        step();
        req_valid[d] = 1'b0;
        n = 1;
        while (resp_valid[d] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("resp_latency", 32'(n), 32'(ws_of(d) + 1));
        rdata = resp_rdata[d];
        err   = resp_err[d];
        for (int k = 0; k < stall; k++) begin
            if (poke) begin
                req_valid[d] = 1'b1;
                req_we[d]    = 1'b1;
                req_addr[d]  = addr;
                req_wdata[d] = 32'hDEAD_BEEF;
            end
            step();
            chk("stall_valid", 32'(resp_valid[d]), 32'd1);
            chk("stall_rdata", resp_rdata[d], rdata);
            chk("stall_err", 32'(resp_err[d]), 32'(err));
            chk("stall_req_ready", 32'(req_ready[d]), 32'd0);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        step();
        resp_ready[d] = 1'b0;
        chk("post_hs_valid", 32'(resp_valid[d]), 32'd0);
        chk("post_hs_rdata", resp_rdata[d], 32'd0);
        chk("post_hs_err", 32'(resp_err[d]), 32'd0);
        chk("post_hs_busy", 32'(busy[d]), 32'd0);
    endtask

    task automatic checked_txn(input int d, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input int stall, input bit poke);
        logic [DW-1:0] exp_rdata, got_rdata;
        bit            exp_err, got_err;
        model_apply(d, we, addr, wdata, exp_rdata, exp_err);
        transact(d, we, addr, wdata, stall, poke, got_rdata, got_err);
        chk("txn_rdata", got_rdata, exp_rdata);
        chk("txn_err", 32'(got_err), 32'(exp_err));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] fib [22];
        logic [DW-1:0] got_rdata, dummy_rdata;
        bit            got_err, dummy_err;
        logic [AW-1:0] a;
        bit            we;

        // Vector table: directed read/write cases, then the Fibonacci image fill and read-back.
        vecs.push_back('{1'b1, 28'h111, 32'h0000_000A, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 28'h111, 32'h0, 32'h0000_000A, 1'b0});
        vecs.push_back('{1'b1, 28'h000, 32'h5A5A_0001, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 28'h400, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 28'h400, 32'h0000_0777, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 28'h000, 32'h0, 32'h5A5A_0001, 1'b0});
        vecs.push_back('{1'b0, 28'h800_0000, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b1, 28'h3FF, 32'hCAFE_F00D, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 28'h3FF, 32'h0, 32'hCAFE_F00D, 1'b0});
        fib[0] = 32'd0;
        fib[1] = 32'd1;
        for (int i = 2; i < 22; i++) fib[i] = fib[i-1] + fib[i-2];
        for (int i = 0; i < 22; i++) vecs.push_back('{1'b1, 28'(32'h100 + i), fib[i], 32'h0, 1'b0});
        for (int i = 0; i < 22; i++) vecs.push_back('{1'b0, 28'(32'h100 + i), 32'h0, fib[i], 1'b0});

        for (int d = 0; d < 2; d++) begin
            reset_n[d]    = 1'b0;
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            resp_ready[d] = 1'b0;
        end
        step();
        step();
        chk("reset_req_ready", 32'(req_ready[0]), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("reset_busy", 32'(busy[0]), 32'd0);
        chk("reset_rdata", resp_rdata[0], 32'd0);
        chk("reset_err", 32'(resp_err[0]), 32'd0);
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        #1;
        chk("ready_low_before_first_edge", 32'(req_ready[0]), 32'd0);
        step();
        chk("ready_after_first_edge", 32'(req_ready[0]), 32'd1);
        chk("ready_after_first_edge_ws0", 32'(req_ready[1]), 32'd1);

        foreach (vecs[i]) begin
            model_apply(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, dummy_rdata, dummy_err);
            transact(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, 1'b0, got_rdata, got_err);
            chk($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
        end

        // Response held for 5 cycles while a conflicting write request is offered.
        checked_txn(0, 1'b0, 28'h111, 32'h0, 5, 1'b1);
        checked_txn(0, 1'b0, 28'h111, 32'h0, 0, 1'b0);

        // Reset during WAIT aborts a pending write to 0x115.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 28'h115;
        req_wdata[0] = 32'hFFFF_FFFF;
        step();
        req_valid[0] = 1'b0;
        chk("wait_busy", 32'(busy[0]), 32'd1);
        chk("wait_req_ready", 32'(req_ready[0]), 32'd0);
        step();
        #2;
        reset_n[0] = 1'b0;
        #1;
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("abort_req_ready", 32'(req_ready[0]), 32'd0);
        step();
        reset_n[0] = 1'b1;
        step();
        chk("abort_ready_back", 32'(req_ready[0]), 32'd1);
        checked_txn(0, 1'b0, 28'h115, 32'h0, 0, 1'b0);

        // Zero wait states: streamed reads of 0x100..0x103, one response every two cycles.
        for (int i = 0; i < 4; i++) checked_txn(1, 1'b1, 28'(32'h100 + i), 32'h1000 + i, 0, 1'b0);
        resp_ready[1] = 1'b1;
        req_we[1]     = 1'b0;
        req_valid[1]  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr[1] = 28'(32'h100 + i);
            step();
            chk("stream_valid", 32'(resp_valid[1]), 32'd1);
            chk("stream_rdata", resp_rdata[1], model_mem[1][10'(32'h100 + i)]);
            chk("stream_err", 32'(resp_err[1]), 32'd0);
            if (i == 3) req_valid[1] = 1'b0;
            step();
            chk("stream_gap", 32'(resp_valid[1]), 32'd0);
            chk("stream_ready", 32'(req_ready[1]), 32'd1);
        end
        resp_ready[1] = 1'b0;

        // Randomized traffic on both instances against the storage model.
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 40; t++) begin
                if ($urandom_range(0, 7) == 0) a = 28'($urandom) | 28'h400;
                else a = 28'(32'h200 + $urandom_range(0, 15));
                we = 1'($urandom_range(0, 1));
                if (a < 28'd1024 && !model_known[d][a[9:0]]) we = 1'b1;
                checked_txn(d, we, a, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
